// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: tracks in-flight predicted branches in an in-order
// FIFO, compares each against the EX outcome, emits the predictor-table
// update, and raises a one-cycle flush with the redirect PC on a mispredict.
// Optional macro BRU_PERF_CNT_EN adds saturating branch/mispredict counters;
// without it both perf ports are tied to 0.
module branch_resolution_unit #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int IDX_W = 5
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              pred_valid,
  input  logic [PC_W-1:0]   pred_pc,
  input  logic              pred_taken,
  output logic              pred_ready,
  input  logic              res_valid,
  input  logic              res_taken,
  input  logic [PC_W-1:0]   res_target,
  output logic              upd_en,
  output logic [IDX_W-1:0]  upd_addr,
  output logic              upd_taken,
  output logic              flush,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              err_underflow,
  output logic [31:0]       perf_branches,
  output logic [31:0]       perf_mispred
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Each entry holds {pc, predicted_taken}
  logic [PC_W:0]      fifo_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [PC_W-1:0]    head_pc;
  logic               head_taken;
  logic               push, pop, mispred, underflow;

  logic               upd_en_q, upd_taken_q, flush_q, err_underflow_q;
  logic [IDX_W-1:0]   upd_addr_q;
  logic [PC_W-1:0]    redirect_pc_q, redirect_pc_d;

  assign head_pc    = fifo_q[rd_ptr_q][PC_W:1];
  assign head_taken = fifo_q[rd_ptr_q][0];

  assign pred_ready = (count_q != CNT_W'(DEPTH));

  // The cycle after a mispredict (flush_q high) ignores both request streams.
  assign push      = pred_valid && pred_ready && !flush_q;
  assign pop       = res_valid && (count_q != '0) && !flush_q;
  assign mispred   = pop && (head_taken != res_taken);
  assign underflow = res_valid && (count_q == '0) && !flush_q;

  assign redirect_pc_d = res_taken ? res_target : (head_pc + PC_W'(4));

  // Next-state pointers/count; a mispredict discards all younger entries,
  // including any push arriving in the same cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (mispred) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  // FIFO control state register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write; contents are only meaningful below count, so no reset
  always_ff @(posedge clk) begin
    if (push && !mispred) fifo_q[wr_ptr_q] <= {pred_pc, pred_taken};
  end

  // Registered resolution outputs, one cycle after the pop
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      upd_en_q        <= 1'b0;
      upd_addr_q      <= '0;
      upd_taken_q     <= 1'b0;
      flush_q         <= 1'b0;
      redirect_pc_q   <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      upd_en_q        <= pop;
      flush_q         <= mispred;
      err_underflow_q <= underflow;
      if (pop) begin
        upd_addr_q  <= head_pc[IDX_W+1:2];
        upd_taken_q <= res_taken;
      end
      if (mispred) redirect_pc_q <= redirect_pc_d;
    end
  end

  assign upd_en        = upd_en_q;
  assign upd_addr      = upd_addr_q;
  assign upd_taken     = upd_taken_q;
  assign flush         = flush_q;
  assign redirect_pc   = redirect_pc_q;
  assign err_underflow = err_underflow_q;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_mp_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating event counters, loaded alongside the update strobe
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      if (pop)     perf_br_q <= sat_inc(perf_br_q);
      if (mispred) perf_mp_q <= sat_inc(perf_mp_q);
    end
  end

  assign perf_branches = perf_br_q;
  assign perf_mispred  = perf_mp_q;
`else
  assign perf_branches = 32'd0;
  assign perf_mispred  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Self-checking bench for branch_resolution_unit: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_branch_resolution_unit;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int IDX_W = 5;

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic              pred_valid = 1'b0;
  logic [PC_W-1:0]   pred_pc = '0;
  logic              pred_taken = 1'b0;
  logic              pred_ready;
  logic              res_valid = 1'b0;
  logic              res_taken = 1'b0;
  logic [PC_W-1:0]   res_target = '0;
  logic              upd_en;
  logic [IDX_W-1:0]  upd_addr;
  logic              upd_taken;
  logic              flush;
  logic [PC_W-1:0]   redirect_pc;
  logic              err_underflow;
  logic [31:0]       perf_branches;
  logic [31:0]       perf_mispred;

  branch_resolution_unit #(.DEPTH(DEPTH), .PC_W(PC_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .arst_n(arst_n),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_en(upd_en), .upd_addr(upd_addr), .upd_taken(upd_taken),
    .flush(flush), .redirect_pc(redirect_pc), .err_underflow(err_underflow),
    .perf_branches(perf_branches), .perf_mispred(perf_mispred)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: in-order list of outstanding predictions
  typedef struct { logic [31:0] pc; logic t; } ent_t;
  ent_t        q[$];
  logic        e_upd, e_take, e_flush, e_under;
  logic [31:0] e_addr, e_red;
  int unsigned m_br, m_mp;

  function automatic void model_reset();
    q.delete();
    e_upd = 0; e_take = 0; e_flush = 0; e_under = 0;
    e_addr = 0; e_red = 0; m_br = 0; m_mp = 0;
  endfunction

  // One clock: drive inputs, advance the model, check outputs after the edge
  task automatic cyc(input logic pv, input logic [31:0] pc, input logic pt,
                     input logic rv, input logic rt, input logic [31:0] tgt);
    int   sz;
    logic ign, n_upd, n_fl, n_un;
    ent_t h;
    pred_valid = pv; pred_pc = pc; pred_taken = pt;
    res_valid = rv; res_taken = rt; res_target = tgt;
    sz  = q.size();
    check("pred_ready", pred_ready, sz != DEPTH);
    ign = e_flush; n_upd = 0; n_fl = 0; n_un = 0;
    if (!ign) begin
      if (rv) begin
        if (sz == 0) n_un = 1;
        else begin
          h = q.pop_front();
          n_upd = 1;
          e_addr = (h.pc >> 2) % (1 << IDX_W);
          e_take = rt;
          m_br++;
          if (h.t != rt) begin
            n_fl = 1;
            m_mp++;
            e_red = rt ? tgt : h.pc + 32'd4;
            q.delete();
          end
        end
      end
      if (pv && sz < DEPTH && !n_fl) q.push_back('{pc: pc, t: pt});
    end
    e_upd = n_upd; e_flush = n_fl; e_under = n_un;
    @(posedge clk); #1;
    check("upd_en", upd_en, e_upd);
    if (e_upd) begin
      check("upd_addr", upd_addr, e_addr);
      check("upd_taken", upd_taken, e_take);
    end
    check("flush", flush, e_flush);
    check("redirect_pc", redirect_pc, e_red);
    check("err_underflow", err_underflow, e_under);
`ifdef BRU_PERF_CNT_EN
    check("perf_branches", perf_branches, m_br);
    check("perf_mispred", perf_mispred, m_mp);
`else
    check("perf_branches", perf_branches, 0);
    check("perf_mispred", perf_mispred, 0);
`endif
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    arst_n = 0;
    #1;
    model_reset();
    check("rst_ready", pred_ready, 1);
    check("rst_upd_en", upd_en, 0);
    check("rst_flush", flush, 0);
    check("rst_redirect", redirect_pc, 0);
    check("rst_underflow", err_underflow, 0);
    check("rst_perf_br", perf_branches, 0);
    @(posedge clk); #2;
    arst_n = 1;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();
    idle();

    // Correct taken
    cyc(1, 32'h40, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h1000);
    check("t1_addr", upd_addr, 5'h10);
    check("t1_taken", upd_taken, 1);
    check("t1_flush", flush, 0);
    idle();

    // Mispredict not-taken, then underflow
    cyc(1, 32'h84, 1, 0, 0, 0);
    cyc(1, 32'h88, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 32'h500);
    check("t2_addr", upd_addr, 5'h01);
    check("t2_flush", flush, 1);
    check("t2_redirect", redirect_pc, 32'h88);
    idle();
    cyc(0, 0, 0, 1, 0, 0);
    check("t2_underflow", err_underflow, 1);
    idle();

    // Mispredict taken
    cyc(1, 32'h100, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h200);
    check("t3_flush", flush, 1);
    check("t3_redirect", redirect_pc, 32'h200);
    check("t3_addr", upd_addr, 5'h00);
    idle();

    // Fill, drop the fifth push, then alternate push/pop across the wrap
    for (int i = 0; i < 5; i++) cyc(1, 32'h1000 + 32'(i * 4), i[0], 0, 0, 0);
    check("full_ready", pred_ready, 0);
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) cyc(0, 0, 0, 1, q[0].t, 32'h3000);
      else cyc(1, 32'h2000 + 32'(i * 4), i[1], 0, 0, 0);
    end
    while (q.size() > 0) cyc(0, 0, 0, 1, q[0].t, 0);
    idle();

    // Reset mid-operation
    for (int i = 0; i < 3; i++) cyc(1, 32'h400 + 32'(i * 4), 1, 0, 0, 0);
    do_reset();
    idle();
    idle();

    // Six resolves, two of them mispredicts
    for (int i = 0; i < 6; i++) begin
      cyc(1, 32'h600 + 32'(i * 4), 1, 0, 0, 0);
      cyc(0, 0, 0, 1, (i == 1 || i == 4) ? 1'b0 : 1'b1, 32'h700);
      idle();
    end
`ifdef BRU_PERF_CNT_EN
    check("perf6_br", perf_branches, 6);
    check("perf6_mp", perf_mispred, 2);
`else
    check("perf6_br_off", perf_branches, 0);
    check("perf6_mp_off", perf_mispred, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic        pv, pt, rv, rt;
      logic [31:0] pc, tgt;
      pv  = ($urandom_range(0, 99) < 55);
      pt  = $urandom_range(0, 1) == 1;
      pc  = $urandom & 32'hFFFF_FFFC;
      if (($urandom_range(0, 49) == 0)) pc = 32'hFFFF_FFFC;
      tgt = $urandom & 32'hFFFF_FFFC;
      rv  = !e_flush && ($urandom_range(0, 99) < 45);
      if (q.size() > 0 && $urandom_range(0, 99) < 70) rt = q[0].t;
      else rt = $urandom_range(0, 1) == 1;
      cyc(pv, pc, pt, rv, rt, tgt);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
